// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-register push/pop sequencer for a downward-growing stack.
//
// A start request latches a register-select mask, a direction and an initial
// stack pointer. Each selected register is then moved one slot at a time.
// Push takes the lowest set bit first, pre-decrements SP and writes.
// Pop takes the highest set bit first, reads at SP and then increments SP.
// Popping DISCARD_BIT only bumps SP and does not touch memory.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   SELECT | pick next register, or finish when nothing is pending
//   ACCESS | memory request outstanding, held until mem_ack
//   DONE   | one-cycle completion pulse
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start/is_pop/mask/sp_in  sequence request (sampled in IDLE)
//   busy, done        status
//   sp_out            working stack pointer
//   reg_sel, reg_rdata, reg_wr, reg_wdata   register-file side
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory side
module stack_sequencer #(
  parameter int MASK_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SP_STEP     = 2,
  parameter int DISCARD_BIT = 5,
  localparam int SEL_W      = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_pop,
  input  logic [MASK_W-1:0] mask,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sp_out,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(SP_STEP);
  localparam logic [MASK_W-1:0] ONE  = MASK_W'(1);

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                pop_q, pop_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [SEL_W-1:0]    lo_idx, hi_idx, sel_idx;
  logic                discard;

  // Lowest and highest pending bit; the later loop assignment wins.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_q[i]) lo_idx = SEL_W'(i);
    end
    for (int i = 0; i < MASK_W; i++) begin
      if (mask_q[i]) hi_idx = SEL_W'(i);
    end
  end

  assign sel_idx = pop_q ? hi_idx : lo_idx;
  assign discard = pop_q && (DISCARD_BIT < MASK_W) && (sel_idx == SEL_W'(DISCARD_BIT));

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pop_d       = pop_q;
    sp_d        = sp_q;
    sel_d       = sel_q;
    reg_wr_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pop_d   = is_pop;
          mask_d  = mask;
          sp_d    = sp_in;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q == '0) begin
          state_d = S_DONE;
        end else if (discard) begin
          sp_d   = sp_q + STEP;
          mask_d = mask_q & ~(ONE << sel_idx);
        end else begin
          sel_d   = sel_idx;
          state_d = S_ACCESS;
          if (pop_q) begin
            mem_we_d   = 1'b0;
            mem_addr_d = sp_q;
          end else begin
            sp_d        = sp_q - STEP;
            mem_we_d    = 1'b1;
            mem_addr_d  = sp_q - STEP;
            mem_wdata_d = reg_rdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          mask_d  = mask_q & ~(ONE << sel_q);
          state_d = S_SELECT;
          if (pop_q) begin
            reg_wr_d    = 1'b1;
            reg_wdata_d = mem_rdata;
            sp_d        = sp_q + STEP;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      pop_q       <= 1'b0;
      sp_q        <= '0;
      sel_q       <= '0;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      pop_q       <= pop_d;
      sp_q        <= sp_d;
      sel_q       <= sel_d;
      reg_wr_q    <= reg_wr_d;
      reg_wdata_q <= reg_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q == S_SELECT) || (state_q == S_ACCESS);
  assign done      = (state_q == S_DONE);
  assign sp_out    = sp_q;
  // While a popped value is being written back, keep pointing at its register;
  // otherwise show the live selection so push data is valid during SELECT.
  assign reg_sel   = (state_q == S_SELECT && !reg_wr_q) ? sel_idx : sel_q;
  assign reg_wr    = reg_wr_q;
  assign reg_wdata = reg_wdata_q;
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, is_pop;
  logic [15:0] mask, sp_in, reg_rdata, mem_rdata;
  logic        mem_ack, auto_ack, man_ack;
  logic        busy, done, reg_wr, mem_req, mem_we;
  logic [15:0] sp_out, reg_wdata, mem_addr, mem_wdata;
  logic [3:0]  reg_sel;

  logic [15:0] regs [16];
  logic [15:0] mem_model [logic [15:0]];

  int n_cmp = 0;
  int n_bad = 0;

  int ack_delay = 0;
  bit ack_en = 1'b1;
  int wcnt = 0;
  logic        acc_we [$];
  logic [15:0] acc_addr [$];
  logic [15:0] acc_data [$];
  logic [3:0]  wr_sel [$];
  logic [15:0] wr_data [$];
  int done_cnt = 0;
  int viol = 0;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_pop(is_pop), .mask(mask),
    .sp_in(sp_in), .busy(busy), .done(done), .sp_out(sp_out), .reg_sel(reg_sel),
    .reg_rdata(reg_rdata), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign reg_rdata = regs[reg_sel];
  assign mem_ack   = auto_ack | man_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay stalled cycles, logs each access.
  initial begin
    auto_ack  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        auto_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req && ack_en) begin
        if (wcnt == ack_delay) begin
          auto_ack = 1'b1;
          acc_we.push_back(mem_we);
          acc_addr.push_back(mem_addr);
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            acc_data.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0;
            acc_data.push_back(mem_rdata);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reg_wr) begin
        wr_sel.push_back(reg_sel);
        wr_data.push_back(reg_wdata);
      end
      if (done) done_cnt++;
      if ((mem_req || reg_wr) && !busy) viol++;
    end
  end

  task automatic run_seq(input logic pop, input logic [15:0] m, input logic [15:0] sp,
                         output int lat);
    @(negedge clk);
    is_pop = pop; mask = m; sp_in = sp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int lat, a0, w0, d0, k;
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
    reset = 1'b1; start = 1'b0; is_pop = 1'b0; mask = '0; sp_in = '0; man_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sp", sp_out, 0);
    chk("rst_sel", reg_sel, 0);
    chk("rst_misc", {reg_wr, mem_req, mem_we}, 0);
    chk("rst_data", {mem_addr, mem_wdata}, 0);
    chk("rst_wdata", reg_wdata, 0);
    reset = 1'b0;

    // Push reg0, reg1 from 0x0100, one stall cycle per ack
    ack_delay = 1; a0 = acc_we.size(); d0 = done_cnt;
    run_seq(1'b0, 16'h0003, 16'h0100, lat);
    chk("push_lat", lat, 8);
    @(negedge clk);
    chk("push_done_1cyc", done, 0);
    chk("push_busy", busy, 0);
    chk("push_sp", sp_out, 16'h00FC);
    chk("push_nacc", acc_we.size() - a0, 2);
    chk("push_acc0", {acc_we[a0], acc_addr[a0], acc_data[a0]}, {1'b1, 16'h00FE, 16'hA000});
    chk("push_acc1", {acc_we[a0+1], acc_addr[a0+1], acc_data[a0+1]}, {1'b1, 16'h00FC, 16'hA001});
    chk("push_donecnt", done_cnt - d0, 1);

    // Pop them back
    ack_delay = 0; a0 = acc_we.size(); w0 = wr_sel.size();
    run_seq(1'b1, 16'h0003, 16'h00FC, lat);
    chk("pop_lat", lat, 6);
    @(negedge clk);
    chk("pop_sp", sp_out, 16'h0100);
    chk("pop_nwr", wr_sel.size() - w0, 2);
    chk("pop_wr0", {wr_sel[w0], wr_data[w0]}, {4'd1, 16'hA001});
    chk("pop_wr1", {wr_sel[w0+1], wr_data[w0+1]}, {4'd0, 16'hA000});
    chk("pop_acc", {acc_we[a0], acc_addr[a0], acc_we[a0+1], acc_addr[a0+1]},
        {1'b0, 16'h00FC, 1'b0, 16'h00FE});

    // Pop with the discard slot
    mem_model[16'h0202] = 16'h1234;
    mem_model[16'h0204] = 16'h5678;
    a0 = acc_we.size(); w0 = wr_sel.size();
    run_seq(1'b1, 16'h0031, 16'h0200, lat);
    chk("disc_lat", lat, 7);
    @(negedge clk);
    chk("disc_sp", sp_out, 16'h0206);
    chk("disc_nacc", acc_we.size() - a0, 2);
    chk("disc_acc", {acc_addr[a0], acc_addr[a0+1]}, {16'h0202, 16'h0204});
    chk("disc_nwr", wr_sel.size() - w0, 2);
    chk("disc_wr0", {wr_sel[w0], wr_data[w0]}, {4'd4, 16'h1234});
    chk("disc_wr1", {wr_sel[w0+1], wr_data[w0+1]}, {4'd0, 16'h5678});

    // SP wrap on push from zero
    a0 = acc_we.size();
    run_seq(1'b0, 16'h0001, 16'h0000, lat);
    @(negedge clk);
    chk("wrap_sp", sp_out, 16'hFFFE);
    chk("wrap_acc", {acc_we[a0], acc_addr[a0], acc_data[a0]}, {1'b1, 16'hFFFE, 16'hA000});

    // Empty mask with start held while busy
    a0 = acc_we.size(); d0 = done_cnt;
    @(negedge clk);
    is_pop = 1'b0; mask = 16'h0000; sp_in = 16'h0400; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    start = 1'b0;
    chk("empty_lat", lat, 2);
    repeat (3) @(negedge clk);
    chk("empty_donecnt", done_cnt - d0, 1);
    chk("empty_busy", busy, 0);
    chk("empty_nacc", acc_we.size() - a0, 0);
    chk("empty_sp", sp_out, 16'h0400);

    // Reset in the middle of a stalled pop access
    ack_en = 1'b0; w0 = wr_sel.size();
    @(negedge clk);
    is_pop = 1'b1; mask = 16'h0002; sp_in = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rstacc_req_seen", mem_req, 1);
    chk("rstacc_addr", mem_addr, 16'h0300);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_req", mem_req, 0);
    chk("rstacc_busy", busy, 0);
    chk("rstacc_sp", sp_out, 0);
    man_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstacc_nwr", wr_sel.size() - w0, 0);
    chk("rstacc_sp_after", sp_out, 0);
    chk("rstacc_idle", {busy, done, mem_req}, 0);
    chk("no_req_outside_busy", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter MASK_W, default 16, meaning the register-select mask width (bit i selects register i).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the stack address and SP width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning the memory word and register width.
REQ-004 SHALL have parameter SP_STEP, default 2, meaning the SP adjustment per slot.
REQ-005 SHALL have parameter DISCARD_BIT, default 5, meaning the mask bit whose pop adjusts SP without a memory read.
REQ-006 SHALL have one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  start  in  1  request new sequence (sampled in IDLE only)
  is_pop  in  1  0=push sequence, 1=pop sequence (latched at start)
  mask  in  MASK_W  registers to transfer (latched at start)
  sp_in  in  ADDR_W  initial SP (latched at start)
  busy  out  1  high from the cycle after start until done
  done  out  1  one-cycle completion pulse
  sp_out  out  ADDR_W  working SP
  reg_sel  out  $clog2(MASK_W)  index of current register
  reg_rdata  in  DATA_W  value of register reg_sel (push source)
  reg_wr  out  1  one-cycle strobe: write reg_wdata to reg_sel
  reg_wdata  out  DATA_W  popped value
  mem_req  out  1  memory request, held until ack
  mem_we  out  1  1=write (push), 0=read (pop)
  mem_addr  out  ADDR_W  word address
  mem_wdata  out  DATA_W  push data
  mem_rdata  in  DATA_W  read data, valid with mem_ack
  mem_ack  in  1  one-cycle acknowledge

Function
REQ-007 SHALL implement states IDLE, SELECT, ACCESS, DONE.
REQ-008 IDLE: start=1 -> latch is_pop, mask, sp_in (to sp_out); go to SELECT; start is ignored in all other states.
REQ-009 SELECT with pending mask zero -> DONE.
REQ-010 SELECT, push: pick lowest set bit; pop: pick highest set bit; drive reg_sel.
REQ-011 Push slot: sp_out <= sp_out - SP_STEP in SELECT; next cycle ACCESS with mem_req=1, mem_we=1, mem_addr=new sp_out, mem_wdata=reg_rdata sampled on SELECT exit.
REQ-012 Pop slot, bit != DISCARD_BIT: ACCESS with mem_req=1, mem_we=0, mem_addr=sp_out.
REQ-013 Pop slot, bit == DISCARD_BIT: no memory access, no reg_wr; sp_out += SP_STEP; bit cleared; remain in SELECT (1 cycle per slot).
REQ-014 ACCESS: mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack=1.
REQ-015 On mem_ack: clear selected bit; pop additionally asserts reg_wr for one cycle with reg_wdata=mem_rdata and sets sp_out += SP_STEP; go to SELECT; mem_req low the cycle after ack.
REQ-016 DONE: done=1 for exactly one cycle, busy=0, go to IDLE; start may be accepted the next cycle.
REQ-017 SP arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-018 Latency: empty mask -> done 2 cycles after start; each memory slot = 2 cycles + ack wait.
REQ-019 reg_wr and mem_req SHALL never be asserted in IDLE or DONE.

Reset
REQ-020 reset SHALL force IDLE in the next cycle from any state and clear the pending mask.
REQ-021 Reset values: busy=0, done=0, sp_out=0, reg_sel=0, reg_wr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_wdata=0.
REQ-022 An ack arriving during or after reset SHALL be ignored.

Verification
REQ-023 Push mask=16'h0003, sp_in=16'h0100, ack after 1 cycle -> writes reg0 @00FE, reg1 @00FC, sp_out=00FC, one done pulse.
REQ-024 Pop mask=16'h0003, sp_in=16'h00FC -> reads @00FC to reg1, @00FE to reg0, two reg_wr pulses, sp_out=0100.
REQ-025 Pop mask=16'h0031, sp_in=16'h0200 -> reg5 discarded (no mem_req, SP +2), reads reg4 @0202, reg0 @0204, final sp_out=0206.
REQ-026 Push mask=16'h0001, sp_in=16'h0000 -> write @FFFE, sp_out=FFFE (wrap).
REQ-027 Empty mask start -> done 2 cycles later, no mem_req; start held while busy -> no second sequence.
REQ-028 Reset asserted during ACCESS with 3-cycle ack stall -> mem_req=0 and IDLE next cycle, later ack causes no reg_wr or SP change.
